lexer_ctrl: RTL and testbench

Sequencer for the character lexer. On START it reads a source byte string from a byte-wide synchronous memory and feeds it one byte per cycle into the lexer's I_VALID/I_DATA input. It then appends flush whitespace so the final token is emitted. It collects lexer tokens into a small token FIFO with a valid/ready output. The lexer has no backpressure, so this block throttles memory reads to keep the FIFO from overflowing.

---
 rtl/lexer_pkg.sv | 25 ++
 rtl/lexer_ctrl_tok_fifo.sv | 60 ++++++
 rtl/lexer_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_lexer_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lexer_pkg.sv
// Shared constants and types for the lexer sequencer: token tags, special
// byte values, controller state encoding and the token FIFO reserve.
package lexer_pkg;

  localparam logic [7:0] TAG_NUM   = 8'h00;
  localparam logic [7:0] TAG_PLUS  = 8'h01;
  localparam logic [7:0] TAG_MINUS = 8'h02;
  localparam logic [7:0] TAG_EOF   = 8'h03;

  localparam logic [7:0] WS_CHAR  = 8'h20;
  localparam logic [7:0] NUL_CHAR = 8'h00;

  // Free FIFO slots required before another byte may be sent toward the lexer:
  // one memory read latency, two lexer pipeline stages and one spare.
  localparam int FIFO_RESERVE = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/lexer_ctrl_tok_fifo.sv
// First-word fall-through token FIFO, 16 bits wide. The head entry is shown
// combinationally on rdata (zero when empty). A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is dropped
// and reported on drop.
module tok_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rdata   = empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage: written at the tail, contents need no reset
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lexer_ctrl.sv
// Lexer sequencer: streams a byte string from synchronous memory into the
// lexer, appends flush spaces, waits for the pipeline to drain and collects
// tokens in a FWFT FIFO. Memory reads are throttled so the FIFO keeps enough
// free slots for every byte already in flight.
// Optional build macro TOK_COUNT_EN adds the TOK_COUNT output (saturating count
// of tokens pushed since the last accepted START).
module lexer_ctrl
  import lexer_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int FLUSH_CHARS  = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W-1:0] LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              MEM_EN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [7:0]        MEM_RDATA,
  output logic              LX_VALID,
  output logic [7:0]        LX_DATA,
  input  logic              LX_TOK_VALID,
  input  logic [15:0]       LX_TOK_DATA,
  output logic              TOK_VALID,
  output logic [15:0]       TOK_DATA,
  input  logic              TOK_READY,
  output logic              OVF
`ifdef TOK_COUNT_EN
  ,
  output logic [ADDR_W-1:0] TOK_COUNT
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FL_W  = $clog2(FLUSH_CHARS + 1);
  localparam int DR_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [DR_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic              lx_vld_p1;
  logic              lx_src_p1;
  logic              ovf_q;

  logic              rd_iss;
  logic              ws_iss;
  logic              accept;
  logic              done;
  logic              nul_hit;
  logic              issue_ok;

  logic              fifo_empty;
  logic              fifo_drop;
  logic [CNT_W-1:0]  fifo_count;

  tok_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (LX_TOK_VALID),
    .pop   (TOK_READY),
    .wdata (LX_TOK_DATA),
    .rdata (TOK_DATA),
    .empty (fifo_empty),
    .count (fifo_count),
    .drop  (fifo_drop)
  );

  assign issue_ok = (fifo_count <= CNT_W'(FIFO_DEPTH - FIFO_RESERVE));
  // A terminator only matters while source bytes are still being read
  assign nul_hit  = (state_q == ST_RUN) && lx_vld_p1 && lx_src_p1 && (MEM_RDATA == NUL_CHAR);

  // Next-state, counters and per-cycle strobes
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    flush_cnt_d = flush_cnt_q;
    drain_cnt_d = drain_cnt_q;
    rd_iss      = 1'b0;
    ws_iss      = 1'b0;
    accept      = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          accept      = 1'b1;
          addr_d      = BASE_ADDR;
          rem_d       = LEN;
          flush_cnt_d = '0;
          drain_cnt_d = '0;
          state_d     = (LEN == '0) ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue_ok) begin
          rd_iss = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == ADDR_W'(1)) state_d = ST_FLUSH;
        end
        if (nul_hit) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // The last flush byte is on LX_DATA during the final FLUSH cycle,
        // so every DRAIN cycle is genuinely idle toward the lexer.
        if (flush_cnt_q < FL_W'(FLUSH_CHARS)) begin
          if (issue_ok) begin
            ws_iss      = 1'b1;
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DR_W'(DRAIN_CYCLES - 1)) state_d = ST_FINISH;
        else drain_cnt_d = drain_cnt_q + 1'b1;
      end
      ST_FINISH: begin
        if (fifo_empty) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and sequencing registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      flush_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      flush_cnt_q <= flush_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Read-return stage: a byte is fed one cycle after its issue; a read issued
  // in the same cycle a terminator returns is discarded
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lx_vld_p1 <= 1'b0;
      lx_src_p1 <= 1'b0;
    end else begin
      lx_vld_p1 <= (rd_iss && !nul_hit) || ws_iss;
      lx_src_p1 <= rd_iss;
    end
  end

  // Sticky overflow flag, cleared by an accepted START
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)           ovf_q <= 1'b0;
    else if (accept)    ovf_q <= 1'b0;
    else if (fifo_drop) ovf_q <= 1'b1;
  end

`ifdef TOK_COUNT_EN
  logic              tok_pushed;
  logic [ADDR_W-1:0] tok_cnt_q;

  assign tok_pushed = LX_TOK_VALID && !fifo_drop;

  // Saturating count of tokens accepted into the FIFO since the last START
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                  tok_cnt_q <= '0;
    else if (accept)                           tok_cnt_q <= ADDR_W'(tok_pushed);
    else if (tok_pushed && (tok_cnt_q != '1))  tok_cnt_q <= tok_cnt_q + 1'b1;
  end

  assign TOK_COUNT = tok_cnt_q;
`endif

  assign MEM_EN    = rd_iss;
  assign MEM_ADDR  = rd_iss ? addr_q : '0;
  assign LX_VALID  = lx_vld_p1;
  assign LX_DATA   = !lx_vld_p1 ? 8'h00 : (lx_src_p1 ? MEM_RDATA : WS_CHAR);
  assign DONE      = done;
  assign BUSY      = (state_q != ST_IDLE) && !done;
  assign TOK_VALID = !fifo_empty;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_lexer_ctrl.sv
// Directed bench for lexer_ctrl with a byte memory model and a small
// behavioural lexer (digits accumulate; a non-digit ends a number; '+' and
// '-' give operator tokens; spaces and NUL give nothing).
module tb_lexer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        lx_valid;
  logic [7:0]  lx_data;
  logic        tok_in_v;
  logic [15:0] tok_in_d;
  logic        tok_valid;
  logic [15:0] tok_data;
  logic        tok_ready;
  logic        ovf;

  logic        inj_v;
  logic [15:0] inj_d;
  logic [15:0] win_lo;
  logic [15:0] win_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lexer_ctrl #(
    .ADDR_W       (16),
    .FIFO_DEPTH   (8),
    .FLUSH_CHARS  (2),
    .DRAIN_CYCLES (3)
  ) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .START        (start),
    .BASE_ADDR    (base_addr),
    .LEN          (len),
    .BUSY         (busy),
    .DONE         (done),
    .MEM_EN       (mem_en),
    .MEM_ADDR     (mem_addr),
    .MEM_RDATA    (mem_rdata),
    .LX_VALID     (lx_valid),
    .LX_DATA      (lx_data),
    .LX_TOK_VALID (tok_in_v),
    .LX_TOK_DATA  (tok_in_d),
    .TOK_VALID    (tok_valid),
    .TOK_DATA     (tok_data),
    .TOK_READY    (tok_ready),
    .OVF          (ovf)
  );

  // Byte memory, one cycle read latency
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr[7:0]];
  end

  // Behavioural lexer: token emitted in the cycle the delimiter is fed
  logic [7:0]  acc_q;
  logic        have_q;
  logic        is_dig;
  logic        lex_tv;
  logic [15:0] lex_td;
  always_comb begin
    is_dig = (lx_data >= 8'h30) && (lx_data <= 8'h39);
    lex_tv = 1'b0;
    lex_td = 16'h0000;
    if (lx_valid && !is_dig) begin
      if (have_q) begin
        lex_tv = 1'b1;
        lex_td = {8'h00, acc_q};
      end else if (lx_data == 8'h2B) begin
        lex_tv = 1'b1;
        lex_td = 16'h0100;
      end else if (lx_data == 8'h2D) begin
        lex_tv = 1'b1;
        lex_td = 16'h0200;
      end
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= 8'h00;
      have_q <= 1'b0;
    end else if (lx_valid) begin
      if (is_dig) begin
        acc_q  <= acc_q * 8'd10 + (lx_data - 8'h30);
        have_q <= 1'b1;
      end else begin
        acc_q  <= 8'h00;
        have_q <= 1'b0;
      end
    end
  end
  assign tok_in_v = lex_tv | inj_v;
  assign tok_in_d = inj_v ? inj_d : lex_td;

  // Event monitor: read issues, bytes fed, completions, popped tokens
  int iss_n = 0, bad_n = 0, lx_n = 0, ws_n = 0, nine_n = 0, done_n = 0, tok_n = 0;
  logic [15:0] tok_log [0:511];
  always @(posedge clk) begin
    if (mem_en) begin
      iss_n <= iss_n + 1;
      if ((mem_addr < win_lo) || (mem_addr > win_hi)) bad_n <= bad_n + 1;
    end
    if (lx_valid) begin
      lx_n <= lx_n + 1;
      if (lx_data == 8'h20) ws_n <= ws_n + 1;
      if (lx_data == 8'h39) nine_n <= nine_n + 1;
    end
    if (done) done_n <= done_n + 1;
    if (tok_valid && tok_ready) begin
      tok_log[tok_n] <= tok_data;
      tok_n <= tok_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] l);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    step(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim, output int cyc);
    cyc = 0;
    while (!done && (cyc < lim)) begin
      step(1);
      cyc++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(busy),     32'd0);
    chk({tag, "_done"},   32'(done),     32'd0);
    chk({tag, "_memen"},  32'(mem_en),   32'd0);
    chk({tag, "_maddr"},  32'(mem_addr), 32'd0);
    chk({tag, "_lxv"},    32'(lx_valid), 32'd0);
    chk({tag, "_lxd"},    32'(lx_data),  32'd0);
    chk({tag, "_tokv"},   32'(tok_valid),32'd0);
    chk({tag, "_tokd"},   32'(tok_data), 32'd0);
    chk({tag, "_ovf"},    32'(ovf),      32'd0);
  endtask

  task automatic load_expr(input int at);
    mem[at + 0] = 8'h31; mem[at + 1] = 8'h32; mem[at + 2] = 8'h20;
    mem[at + 3] = 8'h2B; mem[at + 4] = 8'h20; mem[at + 5] = 8'h33;
  endtask

  task automatic load_stream();
    for (int i = 0; i < 64; i++) mem[i] = (i % 2 == 0) ? 8'h31 : 8'h20;
  endtask

  initial begin
    int t0, i0, l0, w0, n0, d0, cyc, bad;
    rst_n = 1'b0; start = 1'b0; base_addr = 16'h0; len = 16'h0;
    tok_ready = 1'b0; inj_v = 1'b0; inj_d = 16'h0;
    win_lo = 16'h0000; win_hi = 16'hFFFF;
    for (int i = 0; i < 256; i++) mem[i] = 8'h20;
    step(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(2);

    // "12 + 3" with consumer always ready
    load_expr(0);
    tok_ready = 1'b1;
    t0 = tok_n;
    do_start(16'd0, 16'd6);
    chk("expr_busy", 32'(busy), 32'd1);
    wait_done("expr_done", 200, cyc);
    chk("expr_ntok", 32'(tok_n - t0), 32'd3);
    chk("expr_tok0", 32'(tok_log[t0]),     32'h000C);
    chk("expr_tok1", 32'(tok_log[t0 + 1]), 32'h0100);
    chk("expr_tok2", 32'(tok_log[t0 + 2]), 32'h0003);
    chk("expr_ovf",  32'(ovf), 32'd0);
    step(1);
    chk("expr_idle_busy", 32'(busy), 32'd0);

    // LEN=0: only the flush bytes, no tokens, short completion
    l0 = lx_n; w0 = ws_n; t0 = tok_n;
    do_start(16'd0, 16'd0);
    wait_done("len0_done", 50, cyc);
    chk("len0_latency_le7", 32'((cyc + 1) <= 7), 32'd1);
    chk("len0_lx_cycles", 32'(lx_n - l0), 32'd2);
    chk("len0_ws_bytes",  32'(ws_n - w0), 32'd2);
    chk("len0_ntok",      32'(tok_n - t0), 32'd0);
    step(1);

    // 64-byte "1 1 1 ..." with the consumer stalled: reads stop at 5 tokens
    load_stream();
    tok_ready = 1'b0;
    t0 = tok_n; i0 = iss_n;
    do_start(16'd0, 16'd64);
    step(40);
    chk("stall_memen", 32'(mem_en), 32'd0);
    chk("stall_count", 32'(dut.fifo_count), 32'd5);
    chk("stall_tokv",  32'(tok_valid), 32'd1);
    chk("stall_head",  32'(tok_data), 32'h0001);
    chk("stall_ovf",   32'(ovf), 32'd0);
    chk("stall_issued", 32'(iss_n - i0), 32'd11);
    tok_ready = 1'b1;
    wait_done("stall_done", 600, cyc);
    chk("stall_ntok", 32'(tok_n - t0), 32'd32);
    bad = 0;
    for (int i = t0; i < tok_n; i++) if (tok_log[i] !== 16'h0001) bad++;
    chk("stall_tokvals", 32'(bad), 32'd0);
    chk("stall_issued_total", 32'(iss_n - i0), 32'd64);
    chk("stall_ovf_end", 32'(ovf), 32'd0);
    step(1);

    // Terminator in the source: "7 -" NUL "9..." with LEN=10
    mem[100] = 8'h37; mem[101] = 8'h20; mem[102] = 8'h2D; mem[103] = 8'h00;
    for (int i = 104; i < 110; i++) mem[i] = 8'h39;
    t0 = tok_n; n0 = nine_n;
    do_start(16'd100, 16'd10);
    wait_done("nul_done", 200, cyc);
    chk("nul_ntok", 32'(tok_n - t0), 32'd2);
    chk("nul_tok0", 32'(tok_log[t0]),     32'h0007);
    chk("nul_tok1", 32'(tok_log[t0 + 1]), 32'h0200);
    chk("nul_nine_fed", 32'(nine_n - n0), 32'd0);
    step(1);

    // START while busy is ignored
    mem[16] = 8'h35; mem[17] = 8'h20; mem[18] = 8'h36; mem[19] = 8'h20;
    win_lo = 16'd16; win_hi = 16'd19;
    t0 = tok_n; i0 = iss_n; d0 = bad_n;
    do_start(16'd16, 16'd4);
    step(1);
    do_start(16'd100, 16'd9);
    wait_done("busy_start_done", 200, cyc);
    chk("busy_start_issued", 32'(iss_n - i0), 32'd4);
    chk("busy_start_badaddr", 32'(bad_n - d0), 32'd0);
    chk("busy_start_tok0", 32'(tok_log[t0]),     32'h0005);
    chk("busy_start_tok1", 32'(tok_log[t0 + 1]), 32'h0006);
    step(5);
    chk("busy_start_no_rerun", 32'(busy), 32'd0);
    win_lo = 16'h0000; win_hi = 16'hFFFF;

    // FIFO full, simultaneous push/pop, overflow, OVF clear on START (in IDLE)
    tok_ready = 1'b0;
    t0 = tok_n;
    for (int i = 0; i < 8; i++) begin
      inj_v = 1'b1;
      inj_d = 16'(32'hA000 + i);
      step(1);
    end
    inj_v = 1'b0;
    chk("full_count", 32'(dut.fifo_count), 32'd8);
    chk("full_head",  32'(tok_data), 32'hA000);
    chk("full_ovf",   32'(ovf), 32'd0);
    tok_ready = 1'b1; inj_v = 1'b1; inj_d = 16'hA008;
    step(1);
    tok_ready = 1'b0; inj_v = 1'b0;
    chk("pushpop_count", 32'(dut.fifo_count), 32'd8);
    chk("pushpop_head",  32'(tok_data), 32'hA001);
    chk("pushpop_ovf",   32'(ovf), 32'd0);
    inj_v = 1'b1; inj_d = 16'hA009;
    step(1);
    inj_v = 1'b0;
    chk("ovf_set",   32'(ovf), 32'd1);
    chk("ovf_head",  32'(tok_data), 32'hA001);
    tok_ready = 1'b1;
    step(8);
    chk("drain_ntok", 32'(tok_n - t0), 32'd9);
    chk("drain_last", 32'(tok_log[tok_n - 1]), 32'hA008);
    chk("drain_tokv", 32'(tok_valid), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    do_start(16'd0, 16'd0);
    chk("ovf_cleared_by_start", 32'(ovf), 32'd0);
    wait_done("ovf_run_done", 50, cyc);
    step(1);

    // Asynchronous reset in the middle of RUN, then a clean run
    load_stream();
    load_expr(200);
    do_start(16'd0, 16'd64);
    step(10);
    chk("mid_busy",  32'(busy), 32'd1);
    chk("mid_memen", 32'(mem_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    d0 = done_n;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_no_done", 32'(done_n - d0), 32'd0);
    t0 = tok_n;
    do_start(16'd200, 16'd6);
    wait_done("post_rst_done", 200, cyc);
    chk("post_rst_ntok", 32'(tok_n - t0), 32'd3);
    chk("post_rst_tok0", 32'(tok_log[t0]),     32'h000C);
    chk("post_rst_tok1", 32'(tok_log[t0 + 1]), 32'h0100);
    chk("post_rst_tok2", 32'(tok_log[t0 + 2]), 32'h0003);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
